// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment patterns, digit limits and nibble decode
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [3:0] DIGIT_MAX_BCD = 4'd9;
  localparam logic [3:0] DIGIT_MAX_HEX = 4'd15;

  function automatic logic [3:0] digit_max_f(input int hex_mode);
    return (hex_mode != 0) ? DIGIT_MAX_HEX : DIGIT_MAX_BCD;
  endfunction

  function automatic logic [6:0] seg7_decode_f(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_counter_if.sv
// rtl/seg7_scan_counter_if.sv - control inputs and display outputs of the scan counter
interface seg7_scan_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    up_dn;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [6:0]              segments;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  segments, digit_sel, count, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output segments, digit_sel, count, wrap
  );
endinterface

// File: rtl/seg7_digit_cnt.sv
// rtl/seg7_digit_cnt.sv - one BCD/hex digit of the up/down counter chain
module seg7_digit_cnt
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       carry_in,
  input  logic       borrow_in,
  output logic [3:0] value,
  output logic       carry_out
);
  localparam logic [3:0] DIGIT_MAX = digit_max_f(HEX_MODE);

  logic [3:0] load_clamped;

  always_comb begin
    load_clamped = load_val;
    if (load_val > DIGIT_MAX) load_clamped = DIGIT_MAX;
  end

  // carry_out doubles as borrow_out: only one of carry_in/borrow_in is ever set
  assign carry_out = (carry_in && (value == DIGIT_MAX)) || (borrow_in && (value == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 4'd0;
    end else if (load) begin
      value <= load_clamped;
    end else if (carry_in) begin
      value <= (value >= DIGIT_MAX) ? 4'd0 : value + 4'd1;
    end else if (borrow_in) begin
      value <= (value == 4'd0) ? DIGIT_MAX : value - 4'd1;
    end
  end
endmodule

// File: rtl/seg7_scan_counter.sv
// rtl/seg7_scan_counter.sv - N-digit up/down counter driving a multiplexed 7-segment display
module seg7_scan_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 10_000_000,
  parameter int SCAN_DIV       = 10_000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_counter_if.slave  bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_MASK = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] SEL_MASK = {NUM_DIGITS{SEG_ACTIVE_LOW != 0}};

  logic [TW-1:0]   presc;
  logic            tick;
  logic [NUM_DIGITS:0] chain;
  logic [3:0]      digit_val [NUM_DIGITS];
  logic            wrap_r;
  logic [SW-1:0]   scan_cnt;
  logic            scan_step;
  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   scan_idx_next;
  logic [3:0]      sel_nibble;
  logic [6:0]      seg_r;
  logic [NUM_DIGITS-1:0] sel_r;

  assign tick = bus.en && (presc == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (bus.load || tick) begin
      presc <= '0;
    end else if (bus.en) begin
      presc <= presc + TW'(1);
    end
  end

  // A load on the tick cycle swallows that tick
  assign chain[0] = tick && !bus.load;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_digit_cnt #(.HEX_MODE(HEX_MODE)) u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (bus.load),
      .load_val  (bus.load_val[4*g +: 4]),
      .carry_in  (chain[g] && bus.up_dn),
      .borrow_in (chain[g] && !bus.up_dn),
      .value     (digit_val[g]),
      .carry_out (chain[g+1])
    );
  end

  always_comb begin
    bus.count = '0;
    for (int i = 0; i < NUM_DIGITS; i++) bus.count[4*i +: 4] = digit_val[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap_r <= 1'b0;
    else        wrap_r <= chain[NUM_DIGITS];
  end

  assign scan_step = (scan_cnt == SCAN_LAST);

  always_comb begin
    scan_idx_next = scan_idx;
    if (scan_step) scan_idx_next = (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else begin
      scan_cnt <= scan_step ? '0 : scan_cnt + SW'(1);
      scan_idx <= scan_idx_next;
    end
  end

  // Outputs follow the index being entered so digit_sel and segments move together
  assign sel_nibble = digit_val[scan_idx_next];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_0 ^ SEG_MASK;
      sel_r <= NUM_DIGITS'(1) ^ SEL_MASK;
    end else begin
      seg_r <= seg7_decode_f(sel_nibble) ^ SEG_MASK;
      sel_r <= (NUM_DIGITS'(1) << scan_idx_next) ^ SEL_MASK;
    end
  end

  assign bus.segments  = seg_r;
  assign bus.digit_sel = sel_r;
  assign bus.wrap      = wrap_r;
endmodule

// File: doc/seg7_scan_counter.md
Name: seg7_scan_counter

Overview:
- Parametrised successor to the single-digit seven-segment demo counter.
- N-digit up/down counter, decimal or hex, with a loadable value and a prescaled count tick.
- Drives a time-multiplexed multi-digit seven-segment display: one shared segment bus plus one-hot digit select.
- Sits directly under the top-level tt_um wrapper; segments map to uo_out[6:0], control comes from ui_in.

Parameters:
- NUM_DIGITS, 4, number of display digits (1..8); count width is 4*NUM_DIGITS.
- TICK_DIV, 10_000_000, clk cycles per count tick (>=1).
- SCAN_DIV, 10_000, clk cycles per digit scan step (>=1).
- HEX_MODE, 0, 0 = BCD digits 0..9; 1 = hex digits 0..F.
- SEG_ACTIVE_LOW, 0, 1 inverts segments and digit_sel at the output registers.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable; the prescaler holds when low
- up_dn  input  1  1 = count up, 0 = count down
- load  input  1  synchronous load strobe
- load_val  input  4*NUM_DIGITS  value loaded on load, digit 0 = bits [3:0]
- segments  output  7  bit0 = a ... bit6 = g, registered
- digit_sel  output  NUM_DIGITS  one-hot active digit, registered
- count  output  4*NUM_DIGITS  current counter value
- wrap  output  1  one-cycle pulse on roll-over or roll-under

Behaviour:
- Reset, asynchronous: prescaler = 0, scan counter = 0, scan index = 0, count = 0, wrap = 0.
- Reset values: digit_sel = one-hot digit 0; segments = pattern for "0" (0x3F). Both are inverted if SEG_ACTIVE_LOW.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while en = 1.
  - tick asserts for one cycle when prescaler == TICK_DIV-1 and en = 1; the prescaler then wraps to 0.
- Count update (on tick):
  - up_dn = 1: increment digit 0, ripple carry. Each digit wraps at 9 (BCD) or F (hex).
  - up_dn = 0: decrement with borrow; 0 goes to 9 or F.
  - count updates on the clock edge where tick = 1.
- wrap:
  - Asserted the cycle after a tick that takes count from all-max to 0 (up), or from 0 to all-max (down).
  - Never asserted on load.
- Load:
  - load = 1 writes load_val into count at the next edge and clears the prescaler to 0.
  - load beats a simultaneous tick; that tick is discarded.
  - In BCD mode each nibble > 9 is clamped to 9.
- Scan:
  - Independent of en and load.
  - Scan counter runs 0..SCAN_DIV-1. On its terminal value, scan index advances and wraps NUM_DIGITS-1 -> 0.
  - digit_sel and segments are registered together from the same scan index, so both change in the same cycle. Latency from a count change to the visible segment is 1 cycle once the digit is selected.
- Decode:
  - 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
  - BCD mode never presents values > 9.
- Degenerate parameters:
  - NUM_DIGITS = 1: digit_sel is constantly 1.
  - TICK_DIV = 1: tick on every enabled cycle.
  - SCAN_DIV = 1: the digit advances every cycle.
- Reset mid-count or mid-scan returns everything to the reset values immediately, with no glitch pulse on wrap.

Decomposition:
- seg7_pkg holds:
  - the segment pattern constants;
  - the function seg7_decode_f(nibble) -> 7-bit pattern;
  - the localparam for digit max (9/15) derived from HEX_MODE.
- One sub-module, seg7_digit_cnt: a single-digit up/down counter with carry_in/borrow_in and carry_out.
  - Instantiated NUM_DIGITS times in a generate loop.
  - Prescaler, scan logic and output registers stay in the top module.

Test Plan:
- Reset/idle: NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=2, BCD; rst_n low then high, en=0 -> count=0x0000, segments=0x3F, digit_sel=0001, then 0010 after 2 cycles, cycling.
- Count up + ripple: en=1, up_dn=1, load 0x0098; after 2 ticks (8 cycles) -> count=0x0100; while digit 2 is selected, segments=0x06.
- Wrap up/down:
  - load 0x9999 with en=1 -> after 4 cycles count=0x0000 and wrap pulses for exactly 1 cycle.
  - up_dn=0 from 0x0000 -> count=0x9999 with one wrap pulse.
- Load priority and clamp:
  - assert load with 0x00AF on the cycle tick fires -> count=0x0099 (clamped), prescaler restarts, no increment.
  - HEX_MODE=1, same load -> 0x00AF; digit 0 shows 0x71.
- en gating: hold en=0 for 20 cycles mid-prescale -> count unchanged while digit_sel keeps scanning; re-enable -> the tick arrives after the remaining prescale cycles.
- Async reset mid-operation: drop rst_n between clock edges at count=0x1234 -> outputs take reset values immediately with no wrap pulse, and counting restarts from 0 after release.
